// File: rtl/arb_resp_router_pkg.sv
// rtl/arb_resp_router_pkg.sv - shared arbiter types and constants
// Purpose: shared definitions for the two-requester response router.
// Ports: none (package).
package arb_resp_router_pkg;

    // Source tag: index of the requester that won arbitration.
    typedef logic tag_t;

    localparam int NUM_REQ       = 2;
    localparam int DEPTH_DEFAULT = 4;

    // Width of an occupancy count able to hold the value DEPTH itself.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/src_tag_fifo.sv
// rtl/src_tag_fifo.sv - FIFO of one-bit requester tags for outstanding requests
// Purpose: records the requester of each arbitrated request in issue order.
// Ports:
//   clock, reset         - clock, asynchronous active-high reset
//   push, push_tag       - enqueue a tag (ignored when full)
//   pop                  - dequeue the head tag (ignored when empty)
//   full, empty, count   - occupancy, all from registered state
//   head                 - tag at the read pointer
module src_tag_fifo
    import arb_resp_router_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  tag_t             push_tag,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output tag_t             head
);

    localparam logic [PTR_W-1:0] PTR_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    tag_t             mem_q [DEPTH];
    tag_t             mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_tag;
            // Pointers are exactly log2(DEPTH) wide, so they wrap on their own.
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Tag storage needs no reset: entries are only read once count covers them.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/arb_resp_router.sv
// rtl/arb_resp_router.sv - routes in-order responses back to the winning requester
// Purpose: tracks which of two requesters issued each outstanding request and
//          steers the single downstream response stream back in request order.
// Ports:
//   clock, reset                        - clock, asynchronous active-high reset
//   io_req_fire, io_req_src             - arbitrated request and its winner index
//   io_req_allow                        - a tracking entry is free
//   io_resp_valid/ready/bits_*          - downstream response channel
//   io_out_{0,1}_valid/ready/bits_*     - per-requester response channels
//   io_outstanding                      - tracked entry count
//   io_overflow                         - sticky: request fired with no free entry
module arb_resp_router
    import arb_resp_router_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int DATA_W = 64
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       io_req_fire,
    input  logic                       io_req_src,
    output logic                       io_req_allow,
    input  logic                       io_resp_valid,
    output logic                       io_resp_ready,
    input  logic [DATA_W-1:0]          io_resp_bits_data,
    input  logic                       io_resp_bits_error,
    output logic                       io_out_0_valid,
    input  logic                       io_out_0_ready,
    output logic [DATA_W-1:0]          io_out_0_bits_data,
    output logic                       io_out_0_bits_error,
    output logic                       io_out_1_valid,
    input  logic                       io_out_1_ready,
    output logic [DATA_W-1:0]          io_out_1_bits_data,
    output logic                       io_out_1_bits_error,
    output logic [$clog2(DEPTH):0]     io_outstanding,
    output logic                       io_overflow
);

    logic full, empty, pop;
    tag_t head;
    logic overflow_q, overflow_d;

    src_tag_fifo #(.DEPTH(DEPTH)) u_tags (
        .clock    (clock),
        .reset    (reset),
        .push     (io_req_fire),
        .push_tag (tag_t'(io_req_src)),
        .pop      (pop),
        .full     (full),
        .empty    (empty),
        .count    (io_outstanding),
        .head     (head)
    );

    // Allow comes from the registered count only, so the arbiter never sees
    // a loop through its own fire signal.
    assign io_req_allow = ~full;

    // Payload fans out to both channels; only valid is steered by the head tag.
    assign io_out_0_bits_data  = io_resp_bits_data;
    assign io_out_0_bits_error = io_resp_bits_error;
    assign io_out_1_bits_data  = io_resp_bits_data;
    assign io_out_1_bits_error = io_resp_bits_error;

    // Empty is registered, so a tag pushed this cycle cannot route a response
    // until the next cycle.
    always_comb begin
        io_out_0_valid = 1'b0;
        io_out_1_valid = 1'b0;
        io_resp_ready  = 1'b0;
        if (!empty) begin
            if (head == 1'b0) begin
                io_out_0_valid = io_resp_valid;
                io_resp_ready  = io_out_0_ready;
            end else begin
                io_out_1_valid = io_resp_valid;
                io_resp_ready  = io_out_1_ready;
            end
        end
    end

    assign pop = io_resp_valid & io_resp_ready;

    always_comb begin
        overflow_d = overflow_q | (io_req_fire & full);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign io_overflow = overflow_q;

endmodule

// File: tb/tb_arb_resp_router.sv
// tb/tb_arb_resp_router.sv - self-checking bench for arb_resp_router
module tb_arb_resp_router;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 64;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              io_req_fire = 1'b0;
    logic              io_req_src = 1'b0;
    logic              io_req_allow;
    logic              io_resp_valid = 1'b0;
    logic              io_resp_ready;
    logic [DATA_W-1:0] io_resp_bits_data = '0;
    logic              io_resp_bits_error = 1'b0;
    logic              io_out_0_valid;
    logic              io_out_0_ready = 1'b0;
    logic [DATA_W-1:0] io_out_0_bits_data;
    logic              io_out_0_bits_error;
    logic              io_out_1_valid;
    logic              io_out_1_ready = 1'b0;
    logic [DATA_W-1:0] io_out_1_bits_data;
    logic              io_out_1_bits_error;
    logic [2:0]        io_outstanding;
    logic              io_overflow;

    int checks = 0;
    int errors = 0;

    logic sb[$];
    logic model_ovf = 1'b0;
    int   pops = 0;

    arb_resp_router #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clock               (clock),
        .reset               (reset),
        .io_req_fire         (io_req_fire),
        .io_req_src          (io_req_src),
        .io_req_allow        (io_req_allow),
        .io_resp_valid       (io_resp_valid),
        .io_resp_ready       (io_resp_ready),
        .io_resp_bits_data   (io_resp_bits_data),
        .io_resp_bits_error  (io_resp_bits_error),
        .io_out_0_valid      (io_out_0_valid),
        .io_out_0_ready      (io_out_0_ready),
        .io_out_0_bits_data  (io_out_0_bits_data),
        .io_out_0_bits_error (io_out_0_bits_error),
        .io_out_1_valid      (io_out_1_valid),
        .io_out_1_ready      (io_out_1_ready),
        .io_out_1_bits_data  (io_out_1_bits_data),
        .io_out_1_bits_error (io_out_1_bits_error),
        .io_outstanding      (io_outstanding),
        .io_overflow         (io_overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive just after the rising edge, compare against the
    // scoreboard at the falling edge, then advance the model on the rising edge.
    task automatic cycle(input logic f, input logic s, input logic rv,
                         input logic [63:0] d, input logic e,
                         input logic r0, input logic r1);
        int   n;
        logic h, has, ev0, ev1, err;
        io_req_fire = f;  io_req_src = s;
        io_resp_valid = rv; io_resp_bits_data = d; io_resp_bits_error = e;
        io_out_0_ready = r0; io_out_1_ready = r1;
        #4;
        n   = sb.size();
        has = (n > 0);
        h   = has ? sb[0] : 1'b0;
        ev0 = has && !h && rv;
        ev1 = has && h && rv;
        err = has && (h ? r1 : r0);
        check("allow",       64'(io_req_allow),   64'(n < DEPTH));
        check("outstanding", 64'(io_outstanding), 64'(n));
        check("overflow",    64'(io_overflow),    64'(model_ovf));
        check("out0_valid",  64'(io_out_0_valid), 64'(ev0));
        check("out1_valid",  64'(io_out_1_valid), 64'(ev1));
        check("resp_ready",  64'(io_resp_ready),  64'(err));
        check("out0_data",   io_out_0_bits_data,  d);
        check("out1_data",   io_out_1_bits_data,  d);
        check("out0_error",  64'(io_out_0_bits_error), 64'(e));
        check("out1_error",  64'(io_out_1_bits_error), 64'(e));
        if (rv && err) begin
            void'(sb.pop_front());
            pops++;
        end
        if (f) begin
            if (n < DEPTH) sb.push_back(s);
            else           model_ovf = 1'b1;
        end
        @(posedge clock); #1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_values();
        check("rst_allow",       64'(io_req_allow),   64'd1);
        check("rst_resp_ready",  64'(io_resp_ready),  64'd0);
        check("rst_out0_valid",  64'(io_out_0_valid), 64'd0);
        check("rst_out1_valid",  64'(io_out_1_valid), 64'd0);
        check("rst_outstanding", 64'(io_outstanding), 64'd0);
        check("rst_overflow",    64'(io_overflow),    64'd0);
    endtask

    task automatic do_reset_mid_clock();
        // Assert between edges and sample before the next rising edge.
        #2;
        reset = 1'b1;
        io_resp_valid = 1'b1; io_out_0_ready = 1'b1; io_out_1_ready = 1'b1;
        #1;
        check_reset_values();
        sb.delete();
        model_ovf = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [63:0] d;
        logic        s;
        int          p0;

        // Reset state with reset held.
        io_resp_valid = 1'b1; io_out_0_ready = 1'b1; io_out_1_ready = 1'b1;
        #3;
        check_reset_values();
        #9;
        reset = 1'b0;
        @(posedge clock); #1;
        idle();

        // Fires 0,1,1 then D0,D1,D2 with both outputs ready.
        cycle(1, 0, 0, 64'h0, 0, 0, 0);
        cycle(1, 1, 0, 64'h0, 0, 0, 0);
        cycle(1, 1, 0, 64'h0, 0, 0, 0);
        p0 = pops;
        cycle(0, 0, 1, 64'hD0D0_0000_0000_00D0, 0, 1, 1);
        cycle(0, 0, 1, 64'hD1D1_0000_0000_00D1, 1, 1, 1);
        cycle(0, 0, 1, 64'hD2D2_0000_0000_00D2, 0, 1, 1);
        idle();
        check("t1_pops", 64'(pops - p0), 64'd3);

        // Four fires fill the tracker, the fifth overflows and is dropped.
        for (int i = 0; i < 4; i++) cycle(1, 1'(i), 0, 64'h0, 0, 0, 0);
        cycle(1, 1, 0, 64'h0, 0, 0, 0);
        idle();
        check("t2_overflow_sticky", 64'(io_overflow), 64'd1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 64'(100 + i), 0, 1, 1);
        idle();

        // Clear overflow, then a stalled head blocks for five cycles.
        do_reset_mid_clock();
        idle();
        cycle(1, 0, 0, 64'h0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 64'hBEEF, 0, 0, 1);
        p0 = pops;
        cycle(0, 0, 1, 64'hBEEF, 0, 1, 1);
        check("t3_accept_on_ready", 64'(pops - p0), 64'd1);
        idle();

        // Count held at 2 with simultaneous push and pop across pointer wrap.
        cycle(1, 1, 0, 64'h0, 0, 0, 0);
        cycle(1, 0, 0, 64'h0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            s = 1'($urandom_range(0, 1));
            d = {$urandom, $urandom};
            cycle(1, s, 1, d, 1'(i), 1, 1);
        end
        check("t4_count_held", 64'(io_outstanding), 64'd2);
        cycle(0, 0, 1, 64'h11, 0, 1, 1);
        cycle(0, 0, 1, 64'h22, 0, 1, 1);
        idle();

        // Response with nothing outstanding, and in the cycle of the first fire.
        cycle(0, 0, 1, 64'h33, 0, 1, 1);
        cycle(1, 1, 1, 64'h44, 0, 1, 1);
        p0 = pops;
        cycle(0, 0, 1, 64'h44, 0, 1, 1);
        check("t5_accept_after_fire", 64'(pops - p0), 64'd1);
        idle();

        // Reset mid-clock with three outstanding.
        cycle(1, 0, 0, 64'h0, 0, 0, 0);
        cycle(1, 1, 0, 64'h0, 0, 0, 0);
        cycle(1, 0, 0, 64'h0, 0, 0, 0);
        check("t6_pre_reset_count", 64'(io_outstanding), 64'd3);
        do_reset_mid_clock();
        check("t6_post_reset_count", 64'(io_outstanding), 64'd0);
        cycle(0, 0, 1, 64'h55, 0, 1, 1);
        cycle(0, 0, 1, 64'h66, 0, 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
